// File: rtl/frac_div_sequencer.sv
// Fractional-N modulus sequencer: spreads x periods of N+1 evenly over each frame of `total` periods.
// Latency: LOAD takes one clk, then the first period runs; div_pulse/period_done are registered (one clk after terminal count).
// Backpressure: one-deep shadow register; cfg_ready is low while a configuration waits for the next frame boundary.
//
// Ports:
//   clk, rst_n             divider clock, asynchronous active-low reset
//   en                     run enable; dropping it stops the divider at the next frame boundary
//   cfg_valid/cfg_ready    configuration handshake carrying cfg_n, cfg_x, cfg_total
//   div_pulse              one-clk pulse marking the start of each new divider period
//   mod_sel                modulus of the period in progress (0 = N, 1 = N+1)
//   period_done            with div_pulse when a frame has just completed
//   busy                   high in LOAD and RUN
//   cfg_err                one-clk pulse when an offered configuration is rejected
module frac_div_sequencer #(
  parameter int NW = 8,
  parameter int FW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [NW-1:0] cfg_n,
  input  logic [FW-1:0] cfg_x,
  input  logic [FW-1:0] cfg_total,
  output logic          div_pulse,
  output logic          mod_sel,
  output logic          period_done,
  output logic          busy,
  output logic          cfg_err
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  localparam logic [NW-1:0] N_ONE  = NW'(1);
  localparam logic [NW-1:0] N_TWO  = NW'(2);
  localparam logic [NW:0]   N1_ONE = (NW+1)'(1);
  localparam logic [FW-1:0] F_ONE  = FW'(1);

  state_t        state;
  logic [NW-1:0] sh_n, n_q;
  logic [FW-1:0] sh_x, sh_tot, x_q, tot_q;
  logic          pend;      // shadow holds a configuration not yet applied
  logic          have_act;  // an active configuration exists (allows restart without a new cfg)
  logic [NW-1:0] cnt;
  logic [FW-1:0] acc;
  logic [FW-1:0] frame_cnt;

  // One accumulator step: returns {extended, next_acc}. sum is FW+1 bits so
  // acc + x never wraps; when it reaches tot the excess stays below tot.
  function automatic logic [FW:0] mod_step(input logic [FW-1:0] a,
                                           input logic [FW-1:0] x,
                                           input logic [FW-1:0] t);
    logic [FW:0] sum;
    logic [FW:0] diff;
    sum  = {1'b0, a} + {1'b0, x};
    diff = sum - {1'b0, t};
    if (sum >= {1'b0, t}) mod_step = {1'b1, diff[FW-1:0]};
    else                  mod_step = {1'b0, sum[FW-1:0]};
  endfunction

  logic          cfg_ok;
  logic          accept;
  logic [NW-1:0] ld_n;
  logic [FW-1:0] ld_x, ld_tot;
  logic [FW:0]   ld_step, mid_step;
  logic [NW:0]   term_val;
  logic          terminal;
  logic          last_period;

  assign cfg_ok = (cfg_total != '0) && (cfg_x <= cfg_total) && (cfg_n >= N_TWO);
  assign accept = cfg_valid && !pend;

  // Configuration used when a frame starts: a pending shadow wins, otherwise
  // the current active values are reused (restart after en toggling).
  assign ld_n   = pend ? sh_n   : n_q;
  assign ld_x   = pend ? sh_x   : x_q;
  assign ld_tot = pend ? sh_tot : tot_q;

  // Every frame starts from acc = 0, so the first step only needs x and tot.
  assign ld_step  = mod_step('0, ld_x, ld_tot);
  assign mid_step = mod_step(acc, x_q, tot_q);

  // Period length is N or N+1 evaluated at NW+1 bits so N = 2^NW-1 still works.
  assign term_val    = {1'b0, n_q} + {{NW{1'b0}}, mod_sel} - N1_ONE;
  assign terminal    = ({1'b0, cnt} == term_val);
  assign last_period = (frame_cnt == (tot_q - F_ONE));

  assign cfg_ready = !pend;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      sh_n        <= '0;
      sh_x        <= '0;
      sh_tot      <= '0;
      pend        <= 1'b0;
      have_act    <= 1'b0;
      n_q         <= '0;
      x_q         <= '0;
      tot_q       <= '0;
      cnt         <= '0;
      acc         <= '0;
      frame_cnt   <= '0;
      mod_sel     <= 1'b0;
      div_pulse   <= 1'b0;
      period_done <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      div_pulse   <= 1'b0;
      period_done <= 1'b0;
      cfg_err     <= 1'b0;

      // Handshake and consumption never overlap: accept needs !pend,
      // consumption needs pend, so each clear below is guarded by pend.
      if (accept) begin
        if (cfg_ok) begin
          sh_n   <= cfg_n;
          sh_x   <= cfg_x;
          sh_tot <= cfg_total;
          pend   <= 1'b1;
        end else begin
          cfg_err <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          mod_sel <= 1'b0;
          if (en && (pend || have_act)) state <= LOAD;
        end

        LOAD: begin
          n_q       <= ld_n;
          x_q       <= ld_x;
          tot_q     <= ld_tot;
          if (pend) pend <= 1'b0;
          have_act  <= 1'b1;
          cnt       <= '0;
          frame_cnt <= '0;
          mod_sel   <= ld_step[FW];
          acc       <= ld_step[FW-1:0];
          state     <= RUN;
        end

        RUN: begin
          if (terminal) begin
            div_pulse <= 1'b1;
            cnt       <= '0;
            if (last_period) begin
              period_done <= 1'b1;
              frame_cnt   <= '0;
              if (!en) begin
                // Stopping only here keeps every emitted frame complete.
                state   <= IDLE;
                mod_sel <= 1'b0;
                acc     <= '0;
              end else begin
                // Seamless frame start: new config (if any) takes effect with
                // no LOAD bubble.
                n_q     <= ld_n;
                x_q     <= ld_x;
                tot_q   <= ld_tot;
                if (pend) pend <= 1'b0;
                mod_sel <= ld_step[FW];
                acc     <= ld_step[FW-1:0];
              end
            end else begin
              frame_cnt <= frame_cnt + F_ONE;
              mod_sel   <= mid_step[FW];
              acc       <= mid_step[FW-1:0];
            end
          end else begin
            cnt <= cnt + N_ONE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frac_div_sequencer.sv
// Self-checking bench for frac_div_sequencer.
// Reference: period k (1-based) of a frame is extended iff floor(k*x/t) > floor((k-1)*x/t).
// Timing is observed at pulse level: interval between div_pulses, mod_sel at each pulse, period_done.
module tb_frac_div_sequencer;
  localparam int NW = 8;
  localparam int FW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [NW-1:0] cfg_n = '0;
  logic [FW-1:0] cfg_x = '0;
  logic [FW-1:0] cfg_total = '0;
  logic          div_pulse, mod_sel, period_done, busy, cfg_err;

  frac_div_sequencer #(.NW(NW), .FW(FW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_n(cfg_n), .cfg_x(cfg_x), .cfg_total(cfg_total),
    .div_pulse(div_pulse), .mod_sel(mod_sel), .period_done(period_done),
    .busy(busy), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  bit dead = 1'b0;
  int last_t = 0;
  int last_ms = 0;

  typedef struct {
    int n;
    int x;
    int t;
    int err;
    int flen;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic do_reset;
    en = 1'b0;
    cfg_valid = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Offer one configuration; returns at the negedge after the accepting edge.
  task automatic send_cfg(input int n, input int x, input int t);
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_n = NW'(n);
    cfg_x = FW'(x);
    cfg_total = FW'(t);
    for (int i = 0; i < 2000; i++) begin
      if (cfg_ready) begin
        @(negedge clk);
        cfg_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    cfg_valid = 1'b0;
    chk("cfg_handshake_timeout", 0, 1);
  endtask

  task automatic wait_pulse(output int t, output int pd, output int ms, output bit ok);
    t = 0; pd = 0; ms = 0; ok = 1'b0;
    if (dead) return;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (div_pulse) begin
        t = cyc;
        pd = int'(period_done);
        ms = int'(mod_sel);
        ok = 1'b1;
        return;
      end
    end
    dead = 1'b1;
    chk("pulse_timeout", 0, 1);
  endtask

  // Advance to the next frame-start pulse and remember it.
  task automatic sync_frame;
    int t, pd, ms;
    bit ok;
    for (int i = 0; i < 40; i++) begin
      wait_pulse(t, pd, ms, ok);
      if (!ok) return;
      if (pd != 0) begin
        last_t = t;
        last_ms = ms;
        return;
      end
    end
    chk("frame_sync_timeout", 0, 1);
  endtask

  // Check one complete frame starting at the pulse remembered in last_t.
  task automatic check_frame(input int n, input int x, input int t, input string tag);
    int tn, pd, ms, ext;
    bit ok;
    for (int k = 1; k <= t; k++) begin
      ext = (k * x) / t - ((k - 1) * x) / t;
      chk({tag, " mod_sel"}, last_ms, ext);
      wait_pulse(tn, pd, ms, ok);
      if (!ok) return;
      chk({tag, " interval"}, tn - last_t, n + ext);
      chk({tag, " period_done"}, pd, int'(k == t));
      last_t = tn;
      last_ms = ms;
    end
  endtask

  initial begin
    int st, t1, t2, pd, ms, cntv;
    int cn, cx, ct, nn, nx, nt;
    bit ok;

    tbl[0] = '{n:4,   x:1, t:4,  err:0, flen:17};
    tbl[1] = '{n:10,  x:3, t:8,  err:0, flen:83};
    tbl[2] = '{n:6,   x:0, t:1,  err:0, flen:6};
    tbl[3] = '{n:5,   x:3, t:3,  err:0, flen:18};
    tbl[4] = '{n:255, x:1, t:2,  err:0, flen:511};
    tbl[5] = '{n:2,   x:7, t:15, err:0, flen:37};
    tbl[6] = '{n:4,   x:5, t:4,  err:1, flen:0};
    tbl[7] = '{n:4,   x:0, t:0,  err:1, flen:0};
    tbl[8] = '{n:1,   x:1, t:4,  err:1, flen:0};

    // Reset values
    #12;
    chk("rst cfg_ready", int'(cfg_ready), 1);
    chk("rst div_pulse", int'(div_pulse), 0);
    chk("rst mod_sel", int'(mod_sel), 0);
    chk("rst period_done", int'(period_done), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst cfg_err", int'(cfg_err), 0);
    @(negedge clk); rst_n = 1'b1;

    // No configuration ever accepted: en alone must not start anything
    en = 1'b1;
    cntv = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy || div_pulse) cntv++;
    end
    chk("idle without cfg", cntv, 0);

    // Table: valid configs checked over a frame; invalid ones offered while running
    for (int v = 0; v < 9; v++) begin
      do_reset();
      if (tbl[v].err == 0) begin
        send_cfg(tbl[v].n, tbl[v].x, tbl[v].t);
        en = 1'b1;
        sync_frame();
        st = last_t;
        check_frame(tbl[v].n, tbl[v].x, tbl[v].t, $sformatf("tbl%0d", v));
        chk($sformatf("tbl%0d frame_len", v), last_t - st, tbl[v].flen);
      end else begin
        send_cfg(4, 1, 4);
        en = 1'b1;
        sync_frame();
        send_cfg(tbl[v].n, tbl[v].x, tbl[v].t);
        chk($sformatf("tbl%0d cfg_err", v), int'(cfg_err), 1);
        chk($sformatf("tbl%0d cfg_ready", v), int'(cfg_ready), 1);
        @(negedge clk);
        chk($sformatf("tbl%0d cfg_err one-shot", v), int'(cfg_err), 0);
        sync_frame();
        check_frame(4, 1, 4, $sformatf("tbl%0d unchanged", v));
      end
    end

    // Mid-frame reconfiguration 4/1/4 -> 6/0/1
    do_reset();
    send_cfg(4, 1, 4);
    en = 1'b1;
    sync_frame();
    check_frame(4, 1, 4, "reconf pre");
    send_cfg(6, 0, 1);
    chk("reconf ready low", int'(cfg_ready), 0);
    check_frame(4, 1, 4, "reconf old frame");
    chk("reconf ready back", int'(cfg_ready), 1);
    check_frame(6, 0, 1, "reconf new a");
    check_frame(6, 0, 1, "reconf new b");

    // en dropped mid-frame: frame finishes, then silence, then restart
    do_reset();
    send_cfg(4, 1, 4);
    en = 1'b1;
    sync_frame();
    en = 1'b0;
    check_frame(4, 1, 4, "en_low finish");
    chk("en_low busy", int'(busy), 0);
    cntv = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (div_pulse || busy || mod_sel) cntv++;
    end
    chk("en_low silent", cntv, 0);
    en = 1'b1;
    @(negedge clk);
    chk("restart busy", int'(busy), 1);
    wait_pulse(t1, pd, ms, ok);
    wait_pulse(t2, pd, ms, ok);
    if (ok) chk("restart interval", t2 - t1, 4);
    sync_frame();
    check_frame(4, 1, 4, "restart frame");

    // Asynchronous reset during the N+1 period
    do_reset();
    send_cfg(4, 1, 4);
    en = 1'b1;
    sync_frame();
    ms = 0;
    for (int i = 0; i < 12; i++) begin
      wait_pulse(t1, pd, ms, ok);
      if (!ok || ms != 0) break;
    end
    chk("found ext period", ms, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst div_pulse", int'(div_pulse), 0);
    chk("async rst mod_sel", int'(mod_sel), 0);
    chk("async rst busy", int'(busy), 0);
    chk("async rst period_done", int'(period_done), 0);
    chk("async rst cfg_ready", int'(cfg_ready), 1);
    @(negedge clk); rst_n = 1'b1;
    cntv = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy || div_pulse) cntv++;
    end
    chk("idle after reset", cntv, 0);
    send_cfg(6, 0, 1);
    sync_frame();
    check_frame(6, 0, 1, "after reset");

    // Random live reconfiguration against the reference model
    do_reset();
    cn = 4; cx = 1; ct = 4;
    send_cfg(cn, cx, ct);
    en = 1'b1;
    sync_frame();
    for (int it = 0; it < 12; it++) begin
      nn = int'($urandom_range(3, 12));
      nt = int'($urandom_range(1, 8));
      nx = int'($urandom_range(0, nt));
      send_cfg(nn, nx, nt);
      chk($sformatf("rnd%0d ready low", it), int'(cfg_ready), 0);
      check_frame(cn, cx, ct, $sformatf("rnd%0d old", it));
      check_frame(nn, nx, nt, $sformatf("rnd%0d new", it));
      cn = nn; cx = nx; ct = nt;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
